// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one saturating add/sub unit among NUM_REQ requesters.
// Optional macro ADDSUB_ARB_FLAGS_EN adds registered negative/zero flags (rsp_n, rsp_z).
module addsub_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [16*NUM_REQ-1:0]   req_a,
    input  logic [16*NUM_REQ-1:0]   req_b,
    input  logic [NUM_REQ-1:0]      req_sub,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [15:0]             rsp_sum,
`ifdef ADDSUB_ARB_FLAGS_EN
    output logic                    rsp_n,
    output logic                    rsp_z,
`endif
    output logic [15:0]             alu_a,
    output logic [15:0]             alu_b,
    output logic                    alu_sub,
    input  logic [15:0]             alu_sum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // last_grant doubles as the id register: it always holds the owner of the in-flight op.
    logic [ID_W-1:0]    last_grant;
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic [15:0]        sel_a;
    logic [15:0]        sel_b;
    logic               sel_sub;

    // Round-robin scan starting just after the last granted requester.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        sel_a       = '0;
        sel_b       = '0;
        sel_sub     = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_found && req_valid[i] && (i == (int'(last_grant) + k) % NUM_REQ)) begin
                    grant_found = 1'b1;
                    grant_idx   = ID_W'(i);
                    grant_oh[i] = 1'b1;
                    sel_a       = req_a[16*i +: 16];
                    sel_b       = req_b[16*i +: 16];
                    sel_sub     = req_sub[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_found) state_nxt = BUSY;
            BUSY:    state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) ? grant_oh : '0;
        rsp_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= ID_W'(NUM_REQ - 1);
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sub    <= 1'b0;
            rsp_id     <= '0;
            rsp_sum    <= '0;
`ifdef ADDSUB_ARB_FLAGS_EN
            rsp_n      <= 1'b0;
            rsp_z      <= 1'b0;
`endif
        end else begin
            if (state == IDLE && grant_found) begin
                last_grant <= grant_idx;
                alu_a      <= sel_a;
                alu_b      <= sel_b;
                alu_sub    <= sel_sub;
            end
            if (state == BUSY) begin
                rsp_sum <= alu_sum;
                rsp_id  <= last_grant;
`ifdef ADDSUB_ARB_FLAGS_EN
                rsp_n   <= alu_sum[15];
                rsp_z   <= (alu_sum == 16'h0000);
`endif
            end
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter with a saturating adder model on alu_*.
// Flag checks are compiled in when ADDSUB_ARB_FLAGS_EN is defined.
module tb_addsub_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_sub;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [15:0]           rsp_sum;
    logic [15:0]           alu_a;
    logic [15:0]           alu_b;
    logic                  alu_sub;
    logic [15:0]           alu_sum;
`ifdef ADDSUB_ARB_FLAGS_EN
    logic                  rsp_n;
    logic                  rsp_z;
`endif

    int checks   = 0;
    int failures = 0;

    addsub_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
`ifdef ADDSUB_ARB_FLAGS_EN
        .rsp_n     (rsp_n),
        .rsp_z     (rsp_z),
`endif
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sub   (alu_sub),
        .alu_sum   (alu_sum)
    );

    always #5 clk = ~clk;

    // Reference shared unit: 17-bit signed result clamped to 16-bit signed range.
    function automatic logic [15:0] sat_addsub(input logic [15:0] a, input logic [15:0] b, input logic sub);
        logic signed [16:0] r;
        r = sub ? ($signed({a[15], a}) - $signed({b[15], b}))
                : ($signed({a[15], a}) + $signed({b[15], b}));
        if (r > 17'sd32767)       return 16'h7FFF;
        else if (r < -17'sd32768) return 16'h8000;
        else                      return r[15:0];
    endfunction

    assign alu_sum = sat_addsub(alu_a, alu_b, alu_sub);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
        req_valid[i]      = 1'b1;
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_sub[i]        = s;
    endtask

    // Grant requester i alone from IDLE and advance to DONE, checking the response.
    task automatic run_op(input string tag, input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [15:0] exp_sum);
        set_req(i, a, b, s);
        settle();
        check({tag, "_ready"}, 32'(req_ready), 32'(1 << i));
        cyc();
        req_valid[i] = 1'b0;
        settle();
        check({tag, "_busy_valid"}, 32'(rsp_valid), 32'd0);
        cyc();
        settle();
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_sum"}, 32'(rsp_sum), 32'(exp_sum));
        check({tag, "_id"}, 32'(rsp_id), 32'(i));
    endtask

    task automatic finish_op();
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        settle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_id"}, 32'(rsp_id), 32'd0);
        check({tag, "_sum"}, 32'(rsp_sum), 32'd0);
        check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        check({tag, "_alu_sub"}, 32'(alu_sub), 32'd0);
`ifdef ADDSUB_ARB_FLAGS_EN
        check({tag, "_n"}, 32'(rsp_n), 32'd0);
        check({tag, "_z"}, 32'(rsp_z), 32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gnt_idx[$];
        int gnt_cyc[$];
        int rsp_ids[$];
        int rsp_sums[$];

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = 1'b0;
        repeat (2) cyc();
        settle();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Saturating add, then operands held on alu_* after completion.
        run_op("sat_add", 0, 16'h7000, 16'h2000, 1'b0, 16'h7FFF);
        finish_op();
        check("sat_add_release", 32'(rsp_valid), 32'd0);
        check("alu_hold_a", 32'(alu_a), 32'h7000);
        check("alu_hold_b", 32'(alu_b), 32'h2000);

        // Saturating subtract and exact zero.
        run_op("sat_sub", 2, 16'h8000, 16'h0001, 1'b1, 16'h8000);
`ifdef ADDSUB_ARB_FLAGS_EN
        check("sat_sub_n", 32'(rsp_n), 32'd1);
        check("sat_sub_z", 32'(rsp_z), 32'd0);
`endif
        finish_op();
        run_op("zero_sub", 2, 16'h0005, 16'h0005, 1'b1, 16'h0000);
`ifdef ADDSUB_ARB_FLAGS_EN
        check("zero_sub_n", 32'(rsp_n), 32'd0);
        check("zero_sub_z", 32'(rsp_z), 32'd1);
`endif
        finish_op();

        // Backpressure: response held 5 cycles while req1 waits.
        run_op("bp", 0, 16'h1234, 16'h1111, 1'b0, 16'h2345);
        set_req(1, 16'h0100, 16'h0001, 1'b0);
        for (int k = 0; k < 5; k++) begin
            settle();
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_sum", 32'(rsp_sum), 32'h2345);
            check("bp_hold_id", 32'(rsp_id), 32'd0);
            cyc();
        end
        rsp_ready = 1'b1;
        settle();
        check("bp_handshake_ready", 32'(req_ready), 32'd0);
        cyc();
        rsp_ready = 1'b0;
        settle();
        check("bp_next_grant", 32'(req_ready), 32'b0010);
        check("bp_next_valid", 32'(rsp_valid), 32'd0);
        cyc();
        req_valid[1] = 1'b0;
        cyc();
        settle();
        check("bp_req1_sum", 32'(rsp_sum), 32'h0101);
        check("bp_req1_id", 32'(rsp_id), 32'd1);
        finish_op();

        // Round-robin from a fresh pointer with all requesters active.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'(i * 256 + 1), 16'h0010, 1'b0);
        rsp_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            settle();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    gnt_idx.push_back(i);
                    gnt_cyc.push_back(c);
                end
            end
            if (rsp_valid) begin
                rsp_ids.push_back(int'(rsp_id));
                rsp_sums.push_back(int'(rsp_sum));
            end
            cyc();
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        check("rr_grant_count", 32'(gnt_idx.size()), 32'd6);
        check("rr_rsp_count", 32'(rsp_ids.size()), 32'd6);
        for (int n = 0; n < 6; n++) begin
            if (n < gnt_idx.size()) begin
                check("rr_grant_order", 32'(gnt_idx[n]), 32'(n % 4));
                check("rr_grant_cycle", 32'(gnt_cyc[n]), 32'(3 * n));
            end
            if (n < rsp_ids.size()) begin
                check("rr_rsp_id", 32'(rsp_ids[n]), 32'(n % 4));
                check("rr_rsp_sum", 32'(rsp_sums[n]), 32'((n % 4) * 256 + 16'h0011));
            end
        end
        settle();

        // Reset in BUSY: no response, pointer restored (valid 1,3 -> grant 1).
        set_req(1, 16'h0AAA, 16'h0001, 1'b0);
        settle();
        cyc();
        req_valid = '0;
        rst = 1'b1;
        cyc();
        settle();
        check_reset_outputs("rst_busy");
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("rst_busy_no_rsp", 32'(rsp_valid), 32'd0);
        end
        req_valid = 4'b1010;
        settle();
        check("rst_busy_regrant", 32'(req_ready), 32'b0010);
        req_valid = '0;
        settle();

        // Reset in DONE: valid 2,3 -> grant 2 only if pointer restored.
        set_req(2, 16'h0BBB, 16'h0001, 1'b0);
        settle();
        cyc();
        req_valid = '0;
        cyc();
        settle();
        check("rst_done_pending", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        cyc();
        settle();
        check_reset_outputs("rst_done");
        rst = 1'b0;
        cyc();
        check("rst_done_no_rsp", 32'(rsp_valid), 32'd0);
        req_valid = 4'b1100;
        settle();
        check("rst_done_regrant", 32'(req_ready), 32'b0100);
        req_valid = '0;
        settle();

        // Withdrawn request: req3 valid only during BUSY.
        set_req(0, 16'h0003, 16'h0004, 1'b0);
        settle();
        cyc();
        req_valid = '0;
        set_req(3, 16'h0009, 16'h0009, 1'b0);
        settle();
        check("wd_busy_ready", 32'(req_ready), 32'd0);
        cyc();
        req_valid = '0;
        settle();
        check("wd_rsp_id", 32'(rsp_id), 32'd0);
        check("wd_rsp_sum", 32'(rsp_sum), 32'h0007);
        finish_op();
        for (int k = 0; k < 4; k++) begin
            check("wd_no_grant", 32'(req_ready), 32'd0);
            check("wd_no_rsp", 32'(rsp_valid), 32'd0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one 16-bit saturating add/subtract unit (CLA with clamp to 0x7FFF/0x8000) among NUM_REQ requesters.
- Selects requesters by round-robin and drives operands to the shared unit from a register.
- Captures the unit's result and returns it on a valid/ready response channel, tagged with the requester ID.
- Sits between the execute-stage clients (ALU ops, address calc, reduction sequencer) and the single shared adder instance.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, response ID width; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester grant; at most one bit set
- req_a  input  16*NUM_REQ  operand A, requester i at bits [16i+15:16i]
- req_b  input  16*NUM_REQ  operand B, same packing
- req_sub  input  NUM_REQ  1 = A-B, 0 = A+B
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_id  output  ID_W  index of requester owning the response
- rsp_sum  output  16  saturated result
- alu_a  output  16  operand A to shared unit
- alu_b  output  16  operand B to shared unit
- alu_sub  output  1  sub select to shared unit
- alu_sum  input  16  combinational saturated sum from shared unit

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values:
  - state=IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_sum=0.
  - alu_a=0; alu_b=0; alu_sub=0.
  - RR pointer last_grant=NUM_REQ-1, so requester 0 has highest priority first.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - req_ready is combinational, one-hot. It selects the first i with req_valid[i]=1, scanning (last_grant+1) mod NUM_REQ upward with wrap.
  - If no req_valid bit is set, req_ready=0 and the state stays IDLE.
  - On a grant edge: operand reg <= {req_a[i], req_b[i], req_sub[i]}; id reg <= i; last_grant <= i; go to BUSY.
- BUSY (1 cycle):
  - alu_* are driven from the operand reg.
  - rsp_sum <= alu_sum; rsp_id <= id reg; rsp_valid <= 1; go to DONE.
- DONE:
  - rsp_valid=1. rsp_sum and rsp_id are held stable until rsp_ready=1.
  - On the rsp_ready edge: rsp_valid <= 0; go to IDLE.
- req_ready=0 in BUSY and DONE. No overlap of operations.
- Timing:
  - Latency: accept at edge T, rsp_valid=1 after edge T+1.
  - Best-case throughput: one op per 3 cycles.
- alu_* outputs hold their last operands between operations and are not cleared on completion.
- Request rules:
  - A requester keeps req_valid and operands stable until granted.
  - Dropping req_valid before a grant is legal; that request is simply not served.
  - Operand changes after a grant have no effect.
- Arithmetic: this block does no arithmetic. rsp_sum is exactly the alu_sum sampled in BUSY, already clamped to [0x8000, 0x7FFF] by the shared unit.
- Pointer update: the RR pointer changes only on a grant. A requester that is granted gets lowest priority at the next arbitration.
- Reset mid-operation: rst in BUSY or DONE discards the operation without any response, returns to IDLE, and restores all reset values including the pointer.
- Request while a response is pending: a new req_valid in DONE with rsp_ready=1 is not granted that cycle. It is granted the following cycle from IDLE.
- Invalid requests: req_valid bits for indices >= NUM_REQ do not exist. The grant is never X when req_valid is all-zero.

Optional Feature:
- Macro: ADDSUB_ARB_FLAGS_EN.
- Defined:
  - Adds outputs rsp_n (1) and rsp_z (1), registered in BUSY alongside rsp_sum.
  - rsp_n = alu_sum[15]; rsp_z = (alu_sum == 16'h0000).
  - Both reset to 0 and are held through DONE.
- Not defined: rsp_n and rsp_z ports and registers are absent; all other behaviour is identical.

Test Plan:
- Single requester, saturating add: req0 A=0x7000, B=0x2000, sub=0, reference adder model attached -> req_ready[0]=1 in the accept cycle; rsp_valid 2 cycles later; rsp_sum=0x7FFF, rsp_id=0.
- Saturating subtract: req2 A=0x8000, B=0x0001, sub=1 -> rsp_sum=0x8000, rsp_id=2. With FLAGS_EN: rsp_n=1, rsp_z=0. Then A=0x0005, B=0x0005, sub=1 -> rsp_sum=0, rsp_z=1.
- Round-robin: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,1. Grants are spaced 3 cycles apart and rsp_id follows the same order.
- Backpressure: response pending, rsp_ready low for 5 cycles, req1 valid throughout -> rsp_valid/rsp_sum/rsp_id unchanged and req_ready=0 for all 5 cycles. req1 is granted 1 cycle after the rsp_ready handshake.
- Reset mid-op: assert rst in BUSY, then again in another run in DONE -> next cycle rsp_valid=0 and all outputs at reset values. No response is ever produced for the dropped op, and the next grant goes to the lowest-index valid requester.
- Withdrawn request: req3 valid 1 cycle while BUSY, then dropped -> req3 is never granted, and no response carries rsp_id=3.
